// File: rtl/trans_scheduler_if.sv
// -----------------------------------------------------------------------------
// trans_scheduler_if
// Bundles the two requester push ports, the validator issue/done handshake
// and the status outputs of trans_scheduler.
//   slave  : the scheduler side (requester words and validator done in,
//            ready/issue/status out)
//   master : the environment side (requesters, validator, monitors)
// -----------------------------------------------------------------------------
interface trans_scheduler_if;
    logic [127:0] a_data_i;
    logic         a_valid_i;
    logic         a_ready_o;
    logic [127:0] b_data_i;
    logic         b_valid_i;
    logic         b_ready_o;
    logic [127:0] val_data_o;
    logic         val_valid_o;
    logic         val_done_i;
    logic         busy_o;
    logic         timeout_o;
    logic [31:0]  issued_cnt_o;

    modport slave (
        input  a_data_i, a_valid_i, b_data_i, b_valid_i, val_done_i,
        output a_ready_o, b_ready_o, val_data_o, val_valid_o,
               busy_o, timeout_o, issued_cnt_o
    );

    modport master (
        output a_data_i, a_valid_i, b_data_i, b_valid_i, val_done_i,
        input  a_ready_o, b_ready_o, val_data_o, val_valid_o,
               busy_o, timeout_o, issued_cnt_o
    );
endinterface

// File: rtl/trans_scheduler.sv
// -----------------------------------------------------------------------------
// trans_scheduler
// Buffers 128-bit transaction words from two requesters (A, B) in per-requester
// FIFOs and issues them one at a time to a validator, round-robin between the
// requesters. After each issue the scheduler waits for the validator's done
// pulse before granting again. The very first word issued after reset gets
// bit 9 (block start) forced to 1.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   bus        trans_scheduler_if.slave:
//                a/b_data_i, a/b_valid_i, a/b_ready_o  requester push ports
//                val_data_o, val_valid_o, val_done_i   validator handshake
//                busy_o, timeout_o, issued_cnt_o       status
//
// Parameters:
//   FIFO_DEPTH entries per requester FIFO (power of two, 2..16)
//   TIMEOUT    WAIT_DONE cycles before a watchdog abort (1..65535)
//
// Optional feature: define TRANS_SCHEDULER_WATCHDOG_EN to build the WAIT_DONE
// watchdog. Without it timeout_o is tied low and WAIT_DONE only exits on
// val_done_i.
// -----------------------------------------------------------------------------
module trans_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 20000
) (
    input  logic          clk,
    input  logic          rst,
    trans_scheduler_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trans_scheduler: FIFO_DEPTH must be a power of two in 2..16");
    end

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("trans_scheduler: TIMEOUT must be in 1..65535");
    end

    // Index 0 = requester A, index 1 = requester B.
    logic [1:0]   in_valid_s;
    logic [127:0] in_data_s [2];
    logic [127:0] head_s    [2];
    logic [1:0]   ready_s;
    logic [1:0]   not_empty_s;
    logic [1:0]   push_s;
    logic [1:0]   grant_s;
    logic [127:0] head_sel_s;
    logic [127:0] issue_word_s;

    state_t       state_r;
    logic         last_b_r;     // 1: requester B was granted last
    logic         first_r;      // next issue is the first since reset
    logic         val_valid_r;
    logic [127:0] val_data_r;
    logic         busy_r;
    logic [31:0]  issued_r;

    assign in_valid_s   = {bus.b_valid_i, bus.a_valid_i};
    assign in_data_s[0] = bus.a_data_i;
    assign in_data_s[1] = bus.b_data_i;
    assign bus.a_ready_o = ready_s[0];
    assign bus.b_ready_o = ready_s[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [127:0]     mem_r [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr_r;
        logic [PTR_W-1:0] rd_ptr_r;
        logic [CNT_W-1:0] cnt_r;

        // Ready depends on occupancy before any same-cycle pop, so a full
        // FIFO never accepts a word even while its head is leaving.
        assign ready_s[g]     = (cnt_r != FULL_CNT);
        assign not_empty_s[g] = (cnt_r != {CNT_W{1'b0}});
        assign push_s[g]      = in_valid_s[g] & ready_s[g];
        assign head_s[g]      = mem_r[rd_ptr_r];

        // Word storage; contents need no reset because occupancy gates reads.
        always_ff @(posedge clk) begin
            if (!rst && push_s[g]) begin
                mem_r[wr_ptr_r] <= in_data_s[g];
            end
        end

        // Pointers wrap naturally at the power-of-two depth; occupancy tracks
        // push and pop independently so both may happen in one cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                if (push_s[g]) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (grant_s[g]) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push_s[g], grant_s[g]})
                    2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                    2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end
    end

    // Round-robin grant, only evaluated while idle; a grant also pops.
    always_comb begin
        grant_s = 2'b00;
        if (state_r == ST_IDLE) begin
            if (not_empty_s == 2'b11) begin
                grant_s = last_b_r ? 2'b01 : 2'b10;
            end else if (not_empty_s[0]) begin
                grant_s = 2'b01;
            end else if (not_empty_s[1]) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    assign head_sel_s = grant_s[1] ? head_s[1] : head_s[0];

    // Word presented to the validator, with block-start forced on first issue.
    always_comb begin
        issue_word_s    = head_sel_s;
        issue_word_s[9] = head_sel_s[9] | first_r;
    end

`ifdef TRANS_SCHEDULER_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    logic [15:0] wd_r;
    logic        timeout_r;
`endif

    // Issue FSM with registered validator and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_b_r    <= 1'b1;
            first_r     <= 1'b1;
            val_valid_r <= 1'b0;
            val_data_r  <= 128'd0;
            busy_r      <= 1'b0;
            issued_r    <= 32'd0;
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
            wd_r        <= 16'd0;
            timeout_r   <= 1'b0;
`endif
        end else begin
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        val_data_r  <= issue_word_s;
                        val_valid_r <= 1'b1;
                        first_r     <= 1'b0;
                        last_b_r    <= grant_s[1];
                        issued_r    <= issued_r + 32'd1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        val_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    val_valid_r <= 1'b0;
                    busy_r      <= 1'b1;
                    state_r     <= ST_WAIT_DONE;
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
                    wd_r        <= 16'd0;
`endif
                end
                ST_WAIT_DONE: begin
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
                    // timeout_o is raised in the WAIT_DONE cycle where the
                    // count reaches TIMEOUT; the FSM leaves on the next edge.
                    if (wd_r == TIMEOUT_W) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (bus.val_done_i) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        wd_r      <= wd_r + 16'd1;
                        timeout_r <= ((wd_r + 16'd1) == TIMEOUT_W);
                        busy_r    <= 1'b1;
                        state_r   <= ST_WAIT_DONE;
                    end
`else
                    if (bus.val_done_i) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_WAIT_DONE;
                    end
`endif
                end
                default: begin
                    val_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.val_data_o   = val_data_r;
    assign bus.val_valid_o  = val_valid_r;
    assign bus.busy_o       = busy_r;
    assign bus.issued_cnt_o = issued_r;
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
    assign bus.timeout_o    = timeout_r;
`else
    assign bus.timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_trans_scheduler.sv
// -----------------------------------------------------------------------------
// tb_trans_scheduler
// Scoreboard bench: accepted requester words are queued per requester at the
// clock edge that accepts them; a monitor on the opposite edge decides from
// the queues and the round-robin rule which word must be issued next and
// compares data, issue count and ready flags. Directed sequences cover reset,
// latency, spurious done, round-robin order, backpressure, reset in WAIT_DONE
// and the watchdog; a random phase mixes traffic on both requesters.
// -----------------------------------------------------------------------------
module tb_trans_scheduler;
    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trans_scheduler_if bus ();

    trans_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [127:0] d;
        int           stamp;
    } ent_t;

    ent_t         qa[$];
    ent_t         qb[$];
    int           cyc = 0;
    bit           m_first = 1'b1;
    bit           m_last_b = 1'b1;
    logic [31:0]  m_cnt = 32'd0;
    logic [127:0] m_last_data = 128'd0;
    bit           inflight = 1'b0;
    bit           prev_valid = 1'b0;
    int           issue_log[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           hold_done = 0;
    int           fixed_delay = -1;
    int           resp_wait = -1;
    bit           spurious_req = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture accepted words with the edge index that accepted them.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            qa.delete();
            qb.delete();
            m_first     = 1'b1;
            m_last_b    = 1'b1;
            m_cnt       = 32'd0;
            m_last_data = 128'd0;
            inflight    = 1'b0;
        end else begin
            if (bus.a_valid_i && bus.a_ready_o) qa.push_back('{bus.a_data_i, cyc});
            if (bus.b_valid_i && bus.b_ready_o) qb.push_back('{bus.b_data_i, cyc});
            if (bus.val_done_i) inflight = 1'b0;
        end
    end

    // Monitor: a word accepted at edge e can be granted in the cycle after e
    // and shows up on val_valid_o after edge e+1.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.val_valid_o) begin
                bit ea, eb, pick_b, ok;
                logic [127:0] exp;
                ent_t e;
                ea = (qa.size() > 0) && (qa[0].stamp <= cyc - 1);
                eb = (qb.size() > 0) && (qb[0].stamp <= cyc - 1);
                ok = 1'b1;
                pick_b = 1'b0;
                if (ea && eb) pick_b = !m_last_b;
                else if (ea) pick_b = 1'b0;
                else if (eb) pick_b = 1'b1;
                else ok = 1'b0;
                check("valid_not_back_to_back", {127'd0, prev_valid}, 128'd0);
                check("issue_while_inflight", {127'd0, inflight}, 128'd0);
                if (!ok) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL issue_source: got issue %h expected no issue (queues empty)", bus.val_data_o);
                end else begin
                    e = pick_b ? qb.pop_front() : qa.pop_front();
                    exp = e.d;
                    if (m_first) exp[9] = 1'b1;
                    m_first  = 1'b0;
                    m_last_b = pick_b;
                    m_cnt    = m_cnt + 32'd1;
                    check("issue_data", bus.val_data_o, exp);
                    check("issued_cnt", {96'd0, bus.issued_cnt_o}, {96'd0, m_cnt});
                    check("busy_on_issue", {127'd0, bus.busy_o}, 128'd1);
                    m_last_data = exp;
                    inflight = 1'b1;
                    issue_log.push_back(pick_b ? 1 : 0);
                end
            end else begin
                check("data_hold", bus.val_data_o, m_last_data);
            end
            check("a_ready", {127'd0, bus.a_ready_o}, {127'd0, (qa.size() < DEPTH)});
            check("b_ready", {127'd0, bus.b_ready_o}, {127'd0, (qb.size() < DEPTH)});
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
            if (bus.timeout_o) begin
                check("timeout_with_inflight", {127'd0, inflight}, 128'd1);
                inflight = 1'b0;
            end
`else
            check("timeout_tied_low", {127'd0, bus.timeout_o}, 128'd0);
`endif
        end
        prev_valid = bus.val_valid_o;
    end

    // Validator model: done pulse a fixed or random number of cycles after issue.
    always @(negedge clk) begin
        bus.val_done_i = 1'b0;
        if (rst) begin
            resp_wait = -1;
        end else if (spurious_req) begin
            bus.val_done_i = 1'b1;
            spurious_req = 1'b0;
        end else if (bus.val_valid_o) begin
            resp_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(1, 6));
        end else if (resp_wait > 0 && hold_done == 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                bus.val_done_i = 1'b1;
                resp_wait = -1;
            end
        end
    end

    task automatic clear_inputs();
        bus.a_valid_i = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.a_data_i  = 128'd0;
        bus.b_data_i  = 128'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue_log.delete();
    endtask

    task automatic wait_valid(input string name, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.val_valid_o) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no val_valid_o expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < budget && !done_ok; i++) begin
            @(negedge clk);
            if (!bus.busy_o && !bus.val_valid_o && qa.size() == 0 && qb.size() == 0) done_ok = 1'b1;
        end
        n_checks++;
        if (!done_ok) begin
            n_fail++;
            $display("FAIL %s: got busy=%0d qa=%0d qb=%0d expected drained within %0d cycles",
                     name, bus.busy_o, qa.size(), qb.size(), budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit seen;
        int acc, nbad, t0, t1;
        clear_inputs();
        bus.val_done_i = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {127'd0, bus.val_valid_o}, 128'd0);
        check("rst_data", bus.val_data_o, 128'd0);
        check("rst_busy", {127'd0, bus.busy_o}, 128'd0);
        check("rst_timeout", {127'd0, bus.timeout_o}, 128'd0);
        check("rst_cnt", {96'd0, bus.issued_cnt_o}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_ready", {127'd0, bus.a_ready_o}, 128'd1);
        check("rst_b_ready", {127'd0, bus.b_ready_o}, 128'd1);

        // Single word: issue two cycles after the push cycle, bit 9 forced
        bus.a_valid_i = 1'b1;
        bus.a_data_i  = 128'h1;
        @(negedge clk);
        clear_inputs();
        check("single_not_yet", {127'd0, bus.val_valid_o}, 128'd0);
        @(negedge clk);
        check("single_latency", {127'd0, bus.val_valid_o}, 128'd1);
        check("single_bit9", {127'd0, bus.val_data_o[9]}, 128'd1);
        check("single_data", bus.val_data_o, 128'h201);
        check("single_cnt", {96'd0, bus.issued_cnt_o}, 128'd1);
        wait_idle("single_drain", 50);

        // Spurious done while idle
        spurious_req = 1'b1;
        nbad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.val_valid_o || bus.busy_o) nbad++;
        end
        check("spurious_no_activity", 128'(nbad), 128'd0);
        check("spurious_cnt", {96'd0, bus.issued_cnt_o}, 128'd1);

        // Round-robin: A and B three words each, done 5 cycles after issue
        do_reset();
        fixed_delay = 5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_valid_i = 1'b1;
            bus.a_data_i  = {96'd0, 32'hA000_0000 + 32'(i)};
            bus.b_valid_i = 1'b1;
            bus.b_data_i  = {96'd0, 32'hB000_0000 + 32'(i)};
        end
        @(negedge clk);
        clear_inputs();
        wait_idle("rr_drain", 200);
        check("rr_count", 128'(issue_log.size()), 128'd6);
        for (int i = 0; i < 6 && i < issue_log.size(); i++) begin
            check("rr_order", 128'(issue_log[i]), 128'(i % 2));
        end
        fixed_delay = -1;

        // Backpressure: done held low, six A words offered back to back
        do_reset();
        fixed_delay = 1;
        hold_done = 1;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.a_valid_i = 1'b1;
            bus.a_data_i  = {96'd0, 32'hC000_0000 + 32'(acc)};
            if (bus.a_ready_o) acc++;
        end
        @(negedge clk);
        check("bp_accepted", 128'(acc), 128'd5);
        check("bp_ready_low", {127'd0, bus.a_ready_o}, 128'd0);
        hold_done = 0;
        for (int i = 0; i < 40 && acc < 6; i++) begin
            bus.a_data_i = {96'd0, 32'hC000_0000 + 32'(acc)};
            if (bus.a_ready_o) acc++;
            @(negedge clk);
        end
        clear_inputs();
        check("bp_sixth_accepted", 128'(acc), 128'd6);
        wait_idle("bp_drain", 200);
        check("bp_total", {96'd0, bus.issued_cnt_o}, 128'd6);
        fixed_delay = -1;

        // Random traffic on both requesters
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.a_valid_i = 1'($urandom_range(0, 1));
            bus.a_data_i  = {$urandom, $urandom, $urandom, $urandom};
            bus.b_valid_i = 1'($urandom_range(0, 1));
            bus.b_data_i  = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        clear_inputs();
        wait_idle("random_drain", 400);

        // Reset in WAIT_DONE with two words queued
        do_reset();
        fixed_delay = 1;
        hold_done = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_valid_i = 1'b1;
            bus.a_data_i  = {96'd0, 32'hD000_0000 + 32'(i)};
        end
        @(negedge clk);
        clear_inputs();
        check("rstw_busy_before", {127'd0, bus.busy_o}, 128'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_done = 0;
        nbad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.val_valid_o || bus.busy_o) nbad++;
        end
        check("rstw_no_issue", 128'(nbad), 128'd0);
        @(negedge clk);
        bus.a_valid_i = 1'b1;
        bus.a_data_i  = 128'h5;
        @(negedge clk);
        clear_inputs();
        wait_valid("rstw_issue", 10, seen);
        if (seen) begin
            check("rstw_bit9", {127'd0, bus.val_data_o[9]}, 128'd1);
            check("rstw_cnt", {96'd0, bus.issued_cnt_o}, 128'd1);
        end
        wait_idle("rstw_drain", 50);
        fixed_delay = -1;

        // Watchdog behaviour with done never returned
        do_reset();
        fixed_delay = 1;
        hold_done = 1;
        @(negedge clk);
        bus.a_valid_i = 1'b1;
        bus.a_data_i  = {96'd0, 32'hE000_0000};
        @(negedge clk);
        bus.a_data_i  = {96'd0, 32'hE000_0001};
        @(negedge clk);
        clear_inputs();
        check("wd_first_issue", {127'd0, bus.val_valid_o}, 128'd1);
        t0 = cyc;
`ifdef TRANS_SCHEDULER_WATCHDOG_EN
        seen = 1'b0;
        t1 = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.timeout_o) begin
                seen = 1'b1;
                t1 = cyc;
            end
        end
        check("wd_timeout_seen", {127'd0, seen}, 128'd1);
        check("wd_timeout_time", 128'(t1 - t0), 128'd11);
        wait_valid("wd_next_issue", 10, seen);
        if (seen) check("wd_next_latency", 128'(cyc - t1), 128'd2);
        do_reset();
        hold_done = 0;
`else
        nbad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.val_valid_o || bus.timeout_o || !bus.busy_o) nbad++;
        end
        check("wd_off_stays_wait", 128'(nbad), 128'd0);
        hold_done = 0;
        wait_idle("wd_off_drain", 50);
        check("wd_off_cnt", {96'd0, bus.issued_cnt_o}, 128'd2);
`endif
        fixed_delay = -1;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trans_scheduler.md
TRANS_SCHEDULER -- requirements
Module: trans_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per requester FIFO (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 20000, maximum WAIT_DONE cycles before abort (1..65535).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port a_data_i  input  128  requester A transaction word.
REQ-006 SHALL have port a_valid_i  input  1  requester A word valid.
REQ-007 SHALL have port a_ready_o  output  1  requester A FIFO not full.
REQ-008 SHALL have ports b_data_i / b_valid_i / b_ready_o, identical to A, for requester B.
REQ-009 SHALL have port val_data_o  output  128  transaction to validator data_i.
REQ-010 SHALL have port val_valid_o  output  1  one-cycle issue strobe to validator valid_i.
REQ-011 SHALL have port val_done_i  input  1  one-cycle pulse when validator returns to idle.
REQ-012 SHALL have port busy_o  output  1  high when state is not IDLE.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse on watchdog abort.
REQ-014 SHALL have port issued_cnt_o  output  32  transactions issued since reset, wraps.

Function
REQ-015 SHALL push a word into FIFO A when a_valid_i && a_ready_o (B likewise); a_ready_o = FIFO A not full, combinational from occupancy only.
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
REQ-017 IDLE: if either FIFO non-empty, grant one, pop its head into val_data_o register, go ISSUE; else stay.
REQ-018 Arbitration SHALL be round-robin: both non-empty -> grant requester not granted last; one non-empty -> grant it; last-grant updates on every grant.
REQ-019 ISSUE: val_valid_o = 1 for exactly this cycle, issued_cnt_o increments by 1, go WAIT_DONE.
REQ-020 WAIT_DONE: on val_done_i go IDLE; val_done_i in IDLE or ISSUE SHALL be ignored.
REQ-021 val_data_o SHALL hold its value outside ISSUE; val_valid_o SHALL never be high in consecutive cycles.
REQ-022 Latency: word pushed at cycle t into empty FIFO with FSM in IDLE -> val_valid_o high at t+2.
REQ-023 First issue after reset SHALL have bit 9 (block start) forced to 1; later issues pass bit 9 unchanged.
REQ-024 Push to a FIFO in the same cycle its head is popped SHALL be accepted only if not full before the pop (no full-bypass).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL range 0..FIFO_DEPTH.

Reset
REQ-026 On rst: state IDLE, both FIFOs empty, last-grant = B (A wins first tie), first-issue flag set.
REQ-027 On rst: val_valid_o=0, val_data_o=0, busy_o=0, timeout_o=0, issued_cnt_o=0, watchdog=0; a/b_ready_o=1 from next cycle.
REQ-028 rst mid-WAIT_DONE SHALL discard the in-flight transaction and all queued words without issuing.

Configuration
REQ-029 Macro TRANS_SCHEDULER_WATCHDOG_EN: if defined, 16-bit watchdog clears on entering WAIT_DONE, increments each WAIT_DONE cycle, and at count TIMEOUT without val_done_i pulses timeout_o and returns to IDLE.
REQ-030 Without TRANS_SCHEDULER_WATCHDOG_EN: no watchdog logic, timeout_o tied 0, WAIT_DONE exits only on val_done_i; TIMEOUT unused.

Verification
REQ-031 Single word: push A 0x..0001 at t, FSM idle -> val_valid_o at t+2, val_data_o bit 9 = 1, issued_cnt_o = 1.
REQ-032 Round-robin: A and B each hold 3 words, done_i 5 cycles after each issue -> issue order A0 B0 A1 B1 A2 B2.
REQ-033 Backpressure: FIFO_DEPTH=4, hold done_i low, push 6 A words -> a_ready_o low after 5th accepted (1 in flight, 4 queued), no word lost or duplicated.
REQ-034 Spurious done: pulse val_done_i in IDLE -> no state change, no issue.
REQ-035 Watchdog (macro on, TIMEOUT=10): no done_i after issue -> timeout_o pulses 10 cycles after entering WAIT_DONE, next queued word issues 2 cycles later; macro off -> FSM stays WAIT_DONE.
REQ-036 Reset in WAIT_DONE with 2 words queued -> no further val_valid_o, next issue after reset has bit 9 forced to 1, issued_cnt_o restarts at 1.
